// File: rtl/loop_step_sched_if.sv
// Handshake bundle for the two-context loop-step scheduler: load/step
// requests in, grants and per-context loop variables out.
interface loop_step_sched_if;
    logic [1:0]  start;
    logic [14:0] init_j0;
    logic [14:0] init_j1;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [14:0] i0;
    logic [14:0] j0;
    logic [14:0] i1;
    logic [14:0] j1;
    logic [1:0]  busy;
    logic [1:0]  done;

    modport master (
        output start, init_j0, init_j1, req,
        input  gnt, i0, j0, i1, j1, busy, done
    );

    modport slave (
        input  start, init_j0, init_j1, req,
        output gnt, i0, j0, i1, j1, busy, done
    );
endinterface

// File: rtl/loop_step_sched.sv
// Two independent loop contexts (i starts at 1, j at a loaded value) that
// share one step unit (i += 2, j -= 1). A context runs while j >= i and a
// round-robin arbiter picks which requesting context steps each cycle.
module loop_step_sched (
    input  logic          clk,
    input  logic          rst,
    loop_step_sched_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [14:0] RST_I = 15'd1;
    localparam logic [14:0] RST_J = 15'd1000;

    logic [1:0] elig;
    logic [1:0] busy_vec;
    logic [1:0] done_vec;
    logic [1:0] gnt;
    logic       rr_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ctx
        logic [1:0]  state_reg;
        logic [14:0] i_reg;
        logic [14:0] j_reg;
        logic [14:0] init_val;
        logic        elig_w;

        assign init_val = (gi == 0) ? bus.init_j0 : bus.init_j1;

        // A load in the same cycle wins over a step, so it blocks eligibility.
        assign elig_w = (state_reg == ST_RUN) && bus.req[gi] && !bus.start[gi]
                        && (j_reg >= i_reg);

        // Per-context state machine and loop variables.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg <= ST_IDLE;
                i_reg     <= RST_I;
                j_reg     <= RST_J;
            end else if (bus.start[gi]) begin
                state_reg <= ST_RUN;
                i_reg     <= 15'd1;
                j_reg     <= init_val;
            end else if (state_reg == ST_RUN) begin
                if (j_reg < i_reg) begin
                    state_reg <= ST_DONE;
                end else if (gnt[gi]) begin
                    i_reg <= i_reg + 15'd2;
                    j_reg <= j_reg - 15'd1;
                end
            end
        end
    end

    assign elig     = {g_ctx[1].elig_w, g_ctx[0].elig_w};
    assign busy_vec = {g_ctx[1].state_reg == ST_RUN,  g_ctx[0].state_reg == ST_RUN};
    assign done_vec = {g_ctx[1].state_reg == ST_DONE, g_ctx[0].state_reg == ST_DONE};

    // Round-robin choice between eligible contexts; reset suppresses any grant.
    always_comb begin
        gnt = elig;
        if (elig == 2'b11) begin
            gnt = rr_reg ? 2'b10 : 2'b01;
        end
        if (rst) begin
            gnt = 2'b00;
        end
    end

    // Priority pointer moves to the other context after each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg <= 1'b0;
        end else if (gnt[0]) begin
            rr_reg <= 1'b1;
        end else if (gnt[1]) begin
            rr_reg <= 1'b0;
        end
    end

    assign bus.gnt  = gnt;
    assign bus.i0   = g_ctx[0].i_reg;
    assign bus.j0   = g_ctx[0].j_reg;
    assign bus.i1   = g_ctx[1].i_reg;
    assign bus.j1   = g_ctx[1].j_reg;
    assign bus.busy = busy_vec;
    assign bus.done = done_vec;
endmodule

// File: doc/loop_step_sched.md
LOOP_STEP_SCHED -- requirements
Module: loop_step_sched

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 2 bits: per-context load pulse; bit k serves context k.
REQ-004 The block SHALL have the port init_j0, input, 15 bits: j load value for context 0.
REQ-005 The block SHALL have the port init_j1, input, 15 bits: j load value for context 1.
REQ-006 The block SHALL have the port req, input, 2 bits: per-context step request (level).
REQ-007 The block SHALL have the port gnt, output, 2 bits: combinational, one-hot or zero; the step unit is applied to the marked context at the next edge.
REQ-008 The block SHALL have the ports i0, j0, i1, j1, output, 15 bits each: registered loop variables per context.
REQ-009 The block SHALL have the port busy, output, 2 bits: registered; bit k is high in RUN.
REQ-010 The block SHALL have the port done, output, 2 bits: registered; bit k is high in DONE.

Function
REQ-011 Each context SHALL have a state machine with states IDLE, RUN and DONE.
REQ-012 start[k] in any state SHALL load i=1 and j=init_jk, and SHALL set the context to RUN at the next edge; when start[k] is high, gnt[k]=0 that cycle (load beats step).
REQ-013 Context k SHALL be eligible when it is in RUN, req[k]=1, start[k]=0 and jk>=ik (unsigned 15-bit compare).
REQ-014 At most one context SHALL be granted per cycle; one shared step unit: i<=i+2, j<=j-1, both mod 2^15.
REQ-015 Arbitration SHALL be round-robin: a 1-bit pointer rr gives priority when both contexts are eligible; after any grant to context k, rr<=~k; with no grant, rr SHALL hold.
REQ-016 A single eligible context SHALL be granted regardless of rr.
REQ-017 A context in RUN with jk<ik and start[k]=0 SHALL move to DONE at the next edge, holding ik and jk.
REQ-018 A non-granted context SHALL hold ik and jk, including when in RUN with req[k]=0.
REQ-019 DONE SHALL persist until start[k] or rst; IDLE SHALL persist until start[k].
REQ-020 With init_j=1000 and continuous grants, the context SHALL take exactly 334 steps and finish at i=669, j=666.
REQ-021 With init_j=0, the context SHALL take zero steps: RUN for one cycle, then DONE with i=1, j=0.
REQ-022 Contexts SHALL be fully independent apart from the shared grant.

Reset
REQ-023 rst SHALL dominate start and req.
REQ-024 On rst, both contexts SHALL go to IDLE with i0=i1=1 and j0=j1=1000.
REQ-025 On rst, busy and done SHALL be 0, gnt SHALL be 0 in the following cycle, and rr SHALL be 0 (context 0 first).
REQ-026 rst asserted mid-run SHALL abort all progress at that edge.

Verification
REQ-027 Bench SHALL cover: reset; start=01 with init_j0=1000; req=01 held -> 334 cycles of gnt=01, then i0=669, j0=666, done=01 one edge after the last step, gnt=00.
REQ-028 Bench SHALL cover: both started with init 1000, req=11 -> gnt alternates 01,10,01,...; each context finishes after 668 cycles; first grant goes to context 0.
REQ-029 Bench SHALL cover: start=10 with init_j1=0 -> busy[1] for one cycle, then done[1]=1 with i1=1, j1=0; gnt[1] never high.
REQ-030 Bench SHALL cover: both in RUN with req=11 and start=10 pulsed -> gnt=01 that cycle; next edge i1=1, j1=init_j1; context 0 advances.
REQ-031 Bench SHALL cover: req dropped to 00 mid-run for 10 cycles -> gnt=00; i and j frozen; rr unchanged.
REQ-032 Bench SHALL cover: rst pulsed mid-run -> next edge all outputs at reset values; no further grants until a new start.
